hazard_ctrl: RTL and testbench

- Hazard and stall controller for the 5-stage ARM pipeline. It drives the enable/clear controls of the F, D, E, M and W pipeline registers and the E-stage forwarding muxes.
- Resolves three hazard classes:
  - load-use, by stalling and inserting a bubble;
  - PC writes and taken branches, by flushing;
  - a slow data memory, by using a ready handshake to freeze the whole pipeline, with a timeout watchdog.
- Also keeps a saturating stall-cycle performance counter.

---
 rtl/hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and stall controller for the 5-stage ARM pipeline. It resolves
//   load-use hazards by stalling and inserting a bubble, and PC writes or
//   taken branches by flushing. It freezes the whole pipeline while the data
//   memory is not ready, and a watchdog forces a release after MEM_TIMEOUT
//   wait cycles. A saturating counter records the cycles spent with D stalled.
//
// Ports
//   clk, reset                 pipeline clock, asynchronous active-low reset
//   RA1D/RA2D, RA1E/RA2E       source registers in D and E
//   WA3E/WA3M/WA3W             destination registers in E, M, W
//   RegWriteM/RegWriteW        register write pending in M / W
//   MemtoRegE                  load instruction in E
//   PCSrcD/E/M/W               PC-writing instruction in that stage
//   BranchTakenE               branch resolved taken in E
//   MemReqM/MemReadyM          data-memory request / completion in M
//   ForwardAE/ForwardBE        E-stage forwarding selects (00 RF, 01 W, 10 M)
//   StallF..StallW             hold the register feeding that stage
//   FlushD/FlushE              synchronous clear of the D / E registers
//   mem_err                    sticky memory-timeout flag
//   wait_state                 FSM state (00 RUN, 01 WAIT, 10 TOUT)
//   stall_cnt                  saturating count of cycles with StallD high
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       RA1D,
  input  logic [3:0]       RA2D,
  input  logic [3:0]       RA1E,
  input  logic [3:0]       RA2E,
  input  logic [3:0]       WA3E,
  input  logic [3:0]       WA3M,
  input  logic [3:0]       WA3W,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             StallW,
  output logic             FlushD,
  output logic             FlushE,
  output logic             mem_err,
  output logic [1:0]       wait_state,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    WAIT = 2'b01,
    TOUT = 2'b10
  } state_e;

  localparam logic [7:0] TIMEOUT_C = MEM_TIMEOUT[7:0];

  state_e           state_q, state_d;
  logic [7:0]       waitCnt_q, waitCnt_d;
  logic             memErr_q, memErr_d;
  logic [CNT_W-1:0] stallCnt_q, stallCnt_d;

  logic memWaitReq;
  logic memStall;
  logic ldrStall;
  logic pcPend;

  // Forwarding select for one E-stage source. R15 reads PC+8, so it is never
  // forwarded; the M stage holds the younger result and therefore wins over W.
  function automatic logic [1:0] fwdSel(
    input logic [3:0] ra,
    input logic       regWriteM,
    input logic [3:0] wa3M,
    input logic       regWriteW,
    input logic [3:0] wa3W
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (ra != 4'd15) begin
      if (regWriteM && (wa3M == ra))      sel = 2'b10;
      else if (regWriteW && (wa3W == ra)) sel = 2'b01;
    end
    return sel;
  endfunction

  assign memWaitReq = MemReqM & ~MemReadyM;

  // State register: memory-wait FSM, its cycle counter, the sticky timeout
  // flag and the stall performance counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      waitCnt_q  <= 8'd0;
      memErr_q   <= 1'b0;
      stallCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      memErr_q   <= memErr_d;
      stallCnt_q <= stallCnt_d;
    end
  end

  // Next-state logic. The first stalled cycle is spent in RUN, so leaving WAIT
  // at wait_cnt == MEM_TIMEOUT gives MEM_TIMEOUT + 1 stalled cycles in total.
  // TOUT lasts exactly one cycle in which the pipeline is allowed to advance.
  always_comb begin
    state_d    = state_q;
    waitCnt_d  = waitCnt_q;
    memErr_d   = memErr_q;
    stallCnt_d = stallCnt_q;

    case (state_q)
      RUN: begin
        if (memWaitReq) begin
          state_d   = WAIT;
          waitCnt_d = 8'd1;
        end else begin
          waitCnt_d = 8'd0;
        end
      end
      WAIT: begin
        if (!memWaitReq) begin
          state_d   = RUN;
          waitCnt_d = 8'd0;
        end else if (waitCnt_q == TIMEOUT_C) begin
          state_d  = TOUT;
          memErr_d = 1'b1;
        end else begin
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end
      TOUT: begin
        state_d   = RUN;
        waitCnt_d = 8'd0;
      end
      default: begin
        state_d   = RUN;
        waitCnt_d = 8'd0;
      end
    endcase

    if (StallD && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + CNT_W'(1);
    end
  end

  // Output logic. A memory wait freezes every stage and defers flushes: the
  // instruction that asked for the flush is frozen too, so the flush fires on
  // the first cycle after the pipeline is released.
  always_comb begin
    ForwardAE = fwdSel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
    ForwardBE = fwdSel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);

    ldrStall  = MemtoRegE && (WA3E != 4'd15) &&
                ((WA3E == RA1D) || (WA3E == RA2D));
    pcPend    = PCSrcD | PCSrcE | PCSrcM;
    memStall  = memWaitReq && (state_q != TOUT);

    StallF    = ldrStall | pcPend | memStall;
    StallD    = ldrStall | memStall;
    StallE    = memStall;
    StallM    = memStall;
    StallW    = memStall;
    FlushD    = (pcPend | PCSrcW | BranchTakenE) & ~memStall;
    FlushE    = (ldrStall | BranchTakenE) & ~memStall;

    mem_err    = memErr_q;
    wait_state = state_q;
    stall_cnt  = stallCnt_q;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed-vector bench for hazard_ctrl. The stimulus process drives one
//   vector per cycle just after the rising edge and queues the hand-computed
//   expected outputs; an independent monitor pops and compares at every
//   falling edge.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam int CNT_W = 16;

  logic             clk;
  logic             reset;
  logic [3:0]       RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic             RegWriteM, RegWriteW, MemtoRegE;
  logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
  logic             MemReqM, MemReadyM;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, StallM, StallW;
  logic             FlushD, FlushE;
  logic             mem_err;
  logic [1:0]       wait_state;
  logic [CNT_W-1:0] stall_cnt;

  typedef struct {
    string            name;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic [4:0]       st;
    logic [1:0]       fl;
    logic             err;
    logic [1:0]       ws;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             expQ[$];
  int               testsRun = 0;
  int               testsFailed = 0;
  logic [CNT_W-1:0] expCnt = '0;

  hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .StallW(StallW), .FlushD(FlushD), .FlushE(FlushE),
    .mem_err(mem_err), .wait_state(wait_state), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clearInputs();
    RA1D = 4'd0; RA2D = 4'd0; RA1E = 4'd0; RA2E = 4'd0;
    WA3E = 4'd0; WA3M = 4'd0; WA3W = 4'd0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemtoRegE = 1'b0;
    PCSrcD = 1'b0; PCSrcE = 1'b0; PCSrcM = 1'b0; PCSrcW = 1'b0;
    BranchTakenE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  // Queue the expected outputs for the inputs currently applied, then move to
  // just after the next rising edge. st = {F,D,E,M,W}, fl = {FlushD,FlushE}.
  task automatic applyStimulus(input string name, input logic [1:0] fa,
                               input logic [1:0] fb, input logic [4:0] st,
                               input logic [1:0] fl, input logic err,
                               input logic [1:0] ws);
    exp_t e;
    e.name = name; e.fa = fa; e.fb = fb; e.st = st; e.fl = fl;
    e.err = err; e.ws = ws; e.cnt = expCnt;
    expQ.push_back(e);
    if (reset && st[3] && (expCnt != '1)) expCnt = expCnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input string field,
                             input logic [31:0] act, input logic [31:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s.%s: got %0h, expected %0h", name, field, act, req);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput(e.name, "ForwardAE", 32'(ForwardAE), 32'(e.fa));
      checkOutput(e.name, "ForwardBE", 32'(ForwardBE), 32'(e.fb));
      checkOutput(e.name, "Stall", 32'({StallF, StallD, StallE, StallM, StallW}), 32'(e.st));
      checkOutput(e.name, "Flush", 32'({FlushD, FlushE}), 32'(e.fl));
      checkOutput(e.name, "mem_err", 32'(mem_err), 32'(e.err));
      checkOutput(e.name, "wait_state", 32'(wait_state), 32'(e.ws));
      checkOutput(e.name, "stall_cnt", 32'(stall_cnt), 32'(e.cnt));
    end
  end

  initial begin
    reset = 1'b0;
    clearInputs();
    repeat (2) @(posedge clk);
    #1;
    applyStimulus("reset", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 2'b00);
    reset = 1'b1;
    applyStimulus("idle", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 2'b00);

    // Forwarding: M beats W, R15 never forwards.
    RegWriteM = 1'b1; WA3M = 4'd3; RegWriteW = 1'b1; WA3W = 4'd3;
    RA1E = 4'd3; RA2E = 4'd15;
    applyStimulus("fwd_m", 2'b10, 2'b00, 5'b00000, 2'b00, 1'b0, 2'b00);
    RegWriteM = 1'b0;
    applyStimulus("fwd_w", 2'b01, 2'b00, 5'b00000, 2'b00, 1'b0, 2'b00);
    RegWriteM = 1'b1; WA3M = 4'd7; RA2E = 4'd7; WA3W = 4'd15; RA1E = 4'd15;
    applyStimulus("fwd_r15", 2'b00, 2'b10, 5'b00000, 2'b00, 1'b0, 2'b00);
    clearInputs();

    // Load-use stall and bubble.
    MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd1;
    applyStimulus("ldr_use", 2'b00, 2'b00, 5'b11000, 2'b01, 1'b0, 2'b00);
    clearInputs();
    applyStimulus("ldr_after", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 2'b00);
    MemtoRegE = 1'b1; WA3E = 4'd15; RA1D = 4'd15;
    applyStimulus("ldr_r15", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 2'b00);
    clearInputs();

    // Branches and PC writes.
    BranchTakenE = 1'b1;
    applyStimulus("br_taken", 2'b00, 2'b00, 5'b00000, 2'b11, 1'b0, 2'b00);
    clearInputs();
    PCSrcD = 1'b1;
    applyStimulus("pcsrc_d", 2'b00, 2'b00, 5'b10000, 2'b10, 1'b0, 2'b00);
    clearInputs();
    PCSrcW = 1'b1;
    applyStimulus("pcsrc_w", 2'b00, 2'b00, 5'b00000, 2'b10, 1'b0, 2'b00);
    clearInputs();
    MemtoRegE = 1'b1; WA3E = 4'd5; RA1D = 4'd5; BranchTakenE = 1'b1;
    applyStimulus("ldr_br", 2'b00, 2'b00, 5'b11000, 2'b11, 1'b0, 2'b00);
    clearInputs();

    // Memory wait released after three stalled cycles.
    MemReqM = 1'b1;
    applyStimulus("mw_0", 2'b00, 2'b00, 5'b11111, 2'b00, 1'b0, 2'b00);
    applyStimulus("mw_1", 2'b00, 2'b00, 5'b11111, 2'b00, 1'b0, 2'b01);
    applyStimulus("mw_2", 2'b00, 2'b00, 5'b11111, 2'b00, 1'b0, 2'b01);
    MemReadyM = 1'b1;
    applyStimulus("mw_rdy", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 2'b01);
    clearInputs();
    applyStimulus("mw_run", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 2'b00);

    // Timeout: nine stalled cycles, one TOUT cycle, then a fresh wait.
    MemReqM = 1'b1;
    applyStimulus("to_run", 2'b00, 2'b00, 5'b11111, 2'b00, 1'b0, 2'b00);
    for (int i = 1; i <= 8; i++)
      applyStimulus($sformatf("to_wait%0d", i), 2'b00, 2'b00, 5'b11111, 2'b00, 1'b0, 2'b01);
    applyStimulus("to_tout", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b1, 2'b10);
    applyStimulus("to_again", 2'b00, 2'b00, 5'b11111, 2'b00, 1'b1, 2'b00);
    applyStimulus("to_wait_b", 2'b00, 2'b00, 5'b11111, 2'b00, 1'b1, 2'b01);
    MemReadyM = 1'b1;
    applyStimulus("to_rdy", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b1, 2'b01);
    clearInputs();
    applyStimulus("to_run2", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b1, 2'b00);

    // Branch during a memory wait: flushes held until release.
    MemReqM = 1'b1; BranchTakenE = 1'b1;
    applyStimulus("df_0", 2'b00, 2'b00, 5'b11111, 2'b00, 1'b1, 2'b00);
    applyStimulus("df_1", 2'b00, 2'b00, 5'b11111, 2'b00, 1'b1, 2'b01);
    MemReadyM = 1'b1;
    applyStimulus("df_rel", 2'b00, 2'b00, 5'b00000, 2'b11, 1'b1, 2'b01);
    clearInputs();
    applyStimulus("df_run", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b1, 2'b00);

    // Asynchronous reset in the middle of a wait.
    MemReqM = 1'b1;
    applyStimulus("rw_0", 2'b00, 2'b00, 5'b11111, 2'b00, 1'b1, 2'b00);
    applyStimulus("rw_1", 2'b00, 2'b00, 5'b11111, 2'b00, 1'b1, 2'b01);
    #2;
    reset = 1'b0;
    MemReqM = 1'b0;
    expCnt = '0;
    applyStimulus("rw_reset", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 2'b00);
    reset = 1'b1;
    applyStimulus("rw_after", 2'b00, 2'b00, 5'b00000, 2'b00, 1'b0, 2'b00);

    @(negedge clk);
    #1;
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
